// File: rtl/flappy_pkg.sv
//==============================================================================
// Module  : flappy_pkg
// Brief   : Shared state encoding and default sizing for the flappy sequencer.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package flappy_pkg;

    localparam int c_score_w        = 10;
    localparam int c_death_frames   = 30;
    localparam int c_holdoff_frames = 60;
    localparam int c_score_max      = 999;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_DYING     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/flappy_game_ctrl_btn_rise_detect.sv
//==============================================================================
// Module  : btn_rise_detect
// Brief   : Rising-edge detector; history resets high so a held button is no press.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module btn_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic r_btn_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_prev <= 1'b1;
        end else begin
            r_btn_prev <= btn;
        end
    end

    assign press = btn & ~r_btn_prev;

endmodule

`default_nettype wire

// File: rtl/flappy_game_ctrl.sv
//==============================================================================
// Module  : flappy_game_ctrl
// Brief   : IDLE/PLAYING/DYING/GAME_OVER sequencer with score tracking.
//           Define FLAPPY_HISCORE_EN to keep a high score across games.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int DEATH_FRAMES   = c_death_frames,
    parameter int HOLDOFF_FRAMES = c_holdoff_frames,
    parameter int SCORE_W        = c_score_w,
    parameter int SCORE_MAX      = c_score_max
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btn_flap,
    input  logic               pipe_collision,
    input  logic               floor_hit,
    input  logic               pipe_passed,
    output logic               pipe_enable,
    output logic               pipe_reset,
    output logic               bird_enable,
    output logic               flap,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score
);

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_frame_cnt, w_frame_cnt_nxt;
    logic [SCORE_W-1:0] r_score, w_score_nxt;
    logic               r_flap, w_flap_nxt;
    logic               r_pipe_reset, w_pipe_reset_nxt;
    logic               r_pipe_enable, r_bird_enable;
    logic               w_press, w_hit;

    btn_rise_detect u_btn_rise_detect (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_flap),
        .press (w_press)
    );

    assign w_hit = pipe_collision | floor_hit;

    always_comb begin
        w_state_nxt      = r_state;
        w_frame_cnt_nxt  = r_frame_cnt;
        w_score_nxt      = r_score;
        w_flap_nxt       = 1'b0;
        w_pipe_reset_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_state_nxt = ST_PLAYING;
                    w_score_nxt = '0;
                    w_flap_nxt  = 1'b1;
                end
            end
            ST_PLAYING: begin
                // A hit outranks both a flap and a pipe pass in the same cycle.
                if (w_hit) begin
                    w_state_nxt     = ST_DYING;
                    w_frame_cnt_nxt = 8'(DEATH_FRAMES);
                end else begin
                    w_flap_nxt = w_press;
                    if (pipe_passed && (r_score != SCORE_W'(SCORE_MAX))) begin
                        w_score_nxt = r_score + 1'b1;
                    end
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    if (r_frame_cnt <= 8'd1) begin
                        w_state_nxt     = ST_GAME_OVER;
                        w_frame_cnt_nxt = 8'(HOLDOFF_FRAMES);
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt - 8'd1;
                    end
                end
            end
            default: begin
                if (w_press && (r_frame_cnt == 8'd0)) begin
                    w_state_nxt      = ST_IDLE;
                    w_pipe_reset_nxt = 1'b1;
                end else if (frame_tick && (r_frame_cnt != 8'd0)) begin
                    w_frame_cnt_nxt = r_frame_cnt - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_frame_cnt   <= '0;
            r_score       <= '0;
            r_flap        <= 1'b0;
            r_pipe_reset  <= 1'b1;
            r_pipe_enable <= 1'b0;
            r_bird_enable <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_score       <= w_score_nxt;
            r_flap        <= w_flap_nxt;
            r_pipe_reset  <= w_pipe_reset_nxt;
            r_pipe_enable <= (w_state_nxt == ST_PLAYING);
            r_bird_enable <= (w_state_nxt == ST_PLAYING) || (w_state_nxt == ST_DYING);
        end
    end

`ifdef FLAPPY_HISCORE_EN
    logic [SCORE_W-1:0] r_high_score;
    logic               w_game_end;

    assign w_game_end = (r_state == ST_DYING) && (w_state_nxt == ST_GAME_OVER);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_high_score <= '0;
        end else if (w_game_end && (r_score > r_high_score)) begin
            r_high_score <= r_score;
        end
    end

    assign high_score = r_high_score;
`else
    assign high_score = '0;
`endif

    assign state       = r_state;
    assign score       = r_score;
    assign flap        = r_flap;
    assign pipe_reset  = r_pipe_reset;
    assign pipe_enable = r_pipe_enable;
    assign bird_enable = r_bird_enable;

endmodule

`default_nettype wire

// File: tb/tb_flappy_game_ctrl.sv
//==============================================================================
// Module  : tb_flappy_game_ctrl
// Brief   : Directed plus randomized bench against a behavioural game model.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_flappy_game_ctrl;

    localparam int DF = 30;
    localparam int HF = 60;
    localparam int SW = 10;
    localparam int SM = 999;

    logic          clk;
    logic          reset;
    logic          frame_tick;
    logic          btn_flap;
    logic          pipe_collision;
    logic          floor_hit;
    logic          pipe_passed;
    logic          pipe_enable;
    logic          pipe_reset;
    logic          bird_enable;
    logic          flap;
    logic [1:0]    state;
    logic [SW-1:0] score;
    logic [SW-1:0] high_score;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the game, kept as plain integers.
    int m_phase, m_frames, m_score, m_best;
    bit m_last_btn, m_flap, m_prst;

    flappy_game_ctrl #(
        .DEATH_FRAMES   (DF),
        .HOLDOFF_FRAMES (HF),
        .SCORE_W        (SW),
        .SCORE_MAX      (SM)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .btn_flap       (btn_flap),
        .pipe_collision (pipe_collision),
        .floor_hit      (floor_hit),
        .pipe_passed    (pipe_passed),
        .pipe_enable    (pipe_enable),
        .pipe_reset     (pipe_reset),
        .bird_enable    (bird_enable),
        .flap           (flap),
        .state          (state),
        .score          (score),
        .high_score     (high_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pressed;
        bit crashed;
        pressed    = btn_flap && !m_last_btn;
        crashed    = pipe_collision || floor_hit;
        m_flap     = 1'b0;
        m_prst     = 1'b0;
        if (reset) begin
            m_phase = 0; m_frames = 0; m_score = 0; m_best = 0;
            m_last_btn = 1'b1; m_prst = 1'b1;
            return;
        end
        m_last_btn = btn_flap;
        if (m_phase == 0) begin
            if (pressed) begin
                m_phase = 1; m_score = 0; m_flap = 1'b1;
            end
        end else if (m_phase == 1) begin
            if (crashed) begin
                m_phase = 2; m_frames = DF;
            end else begin
                m_flap = pressed;
                if (pipe_passed) m_score = (m_score + 1 > SM) ? SM : m_score + 1;
            end
        end else if (m_phase == 2) begin
            if (frame_tick) begin
                m_frames = m_frames - 1;
                if (m_frames == 0) begin
`ifdef FLAPPY_HISCORE_EN
                    if (m_score > m_best) m_best = m_score;
`endif
                    m_phase = 3; m_frames = HF;
                end
            end
        end else begin
            if (pressed && m_frames == 0) begin
                m_phase = 0; m_prst = 1'b1;
            end else if (frame_tick && m_frames > 0) begin
                m_frames = m_frames - 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("state", 32'(state), 32'(m_phase));
        chk("pipe_enable", 32'(pipe_enable), 32'(m_phase == 1));
        chk("bird_enable", 32'(bird_enable), 32'(m_phase == 1 || m_phase == 2));
        chk("flap", 32'(flap), 32'(m_flap));
        chk("pipe_reset", 32'(pipe_reset), 32'(m_prst));
        chk("score", 32'(score), 32'(m_score));
        chk("high_score", 32'(high_score), 32'(m_best));
    endtask

    task automatic press_btn();
        btn_flap = 1'b0; step();
        btn_flap = 1'b1; step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1; step();
            frame_tick = 1'b0; step();
        end
    endtask

    task automatic passes(input int n);
        for (int i = 0; i < n; i++) begin
            pipe_passed = 1'b1; step();
            pipe_passed = 1'b0; step();
        end
    endtask

    task automatic play_game(input int n);
        press_btn();
        passes(n);
        pipe_collision = 1'b1; step();
        pipe_collision = 1'b0;
        ticks(DF + HF);
        press_btn();
    endtask

    initial begin
        reset = 1'b1; btn_flap = 1'b1; frame_tick = 1'b0;
        pipe_collision = 1'b0; floor_hit = 1'b0; pipe_passed = 1'b0;
        repeat (3) step();
        chk("rst_pipe_reset", 32'(pipe_reset), 32'd1);

        reset = 1'b0; step();
        chk("rel_state", 32'(state), 32'd0);
        chk("rel_pipe_reset", 32'(pipe_reset), 32'd0);

        press_btn();
        chk("start_state", 32'(state), 32'd1);
        chk("start_flap", 32'(flap), 32'd1);
        step();
        chk("flap_one_cycle", 32'(flap), 32'd0);

        passes(5);
        chk("score5", 32'(score), 32'd5);
        passes(SM - 5);
        passes(2);
        chk("score_sat", 32'(score), 32'(SM));

        floor_hit = 1'b1; step();
        floor_hit = 1'b0;
        chk("floor_dying", 32'(state), 32'd2);
        ticks(DF - 1);
        chk("still_dying", 32'(state), 32'd2);
        ticks(1);
        chk("game_over", 32'(state), 32'd3);
        ticks(10);
        press_btn();
        chk("holdoff_ignored", 32'(state), 32'd3);
        ticks(HF - 10);
        press_btn();
        chk("back_idle", 32'(state), 32'd0);
        chk("idle_pipe_reset", 32'(pipe_reset), 32'd1);
        chk("score_held", 32'(score), 32'(SM));
        step();
        chk("pipe_reset_once", 32'(pipe_reset), 32'd0);

        // Hit and pass together at score 3: the hit wins.
        reset = 1'b1; step(); reset = 1'b0; step();
        press_btn();
        passes(3);
        pipe_collision = 1'b1; pipe_passed = 1'b1; step();
        pipe_collision = 1'b0; pipe_passed = 1'b0;
        chk("hit_wins_state", 32'(state), 32'd2);
        chk("hit_wins_score", 32'(score), 32'd3);
        chk("hit_pipe_en", 32'(pipe_enable), 32'd0);
        ticks(DF + HF);
        press_btn();
        chk("score3_held", 32'(score), 32'd3);

        reset = 1'b1; step(); reset = 1'b0; step();
        play_game(7);
        play_game(4);
`ifdef FLAPPY_HISCORE_EN
        chk("hiscore", 32'(high_score), 32'd7);
`else
        chk("hiscore", 32'(high_score), 32'd0);
`endif

        press_btn();
        pipe_collision = 1'b1; step(); pipe_collision = 1'b0;
        ticks(5);
        reset = 1'b1; step();
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_bird", 32'(bird_enable), 32'd0);
        chk("mid_rst_pipe_reset", 32'(pipe_reset), 32'd1);
        reset = 1'b0; step();

        for (int i = 0; i < 6000; i++) begin
            reset          = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 7) == 0) btn_flap = ~btn_flap;
            pipe_collision = ($urandom_range(0, 199) == 0);
            floor_hit      = ($urandom_range(0, 199) == 0);
            pipe_passed    = ($urandom_range(0, 9) == 0);
            frame_tick     = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
